node_sequencer: RTL and testbench
=================================

# node_sequencer

Instruction-driven sequencer for the wireless sensor node. It accepts 3-bit instructions from the host, samples the sensor, and stores samples in the 16×8 node memory, used as a circular buffer. On command it drains the stored bytes, in order, to the IPv6 packetiser. It also owns the radio enable. It sits between the node top level and the sensor, memory, packetiser and radio, and replaces ad-hoc strobe wiring with one arbitrated owner of the memory port.

## Interface
- MEM_DEPTH, 16: buffer entries; address width is log2(MEM_DEPTH) = 4.
- SETTLE_CYCLES, 2: cycles sensor_enable is held high before sensor_data is captured (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  global enable; low aborts any operation (see Operation).
- inst  in  3  opcode.
- inst_valid  in  1  opcode valid.
- inst_ready  out  1  opcode accepted when inst_valid & inst_ready.
- busy  out  1  high whenever state ≠ IDLE.
- sensor_enable  out  1  sensor power/convert strobe.
- sensor_data  in  8  sensor sample.
- mem_addr  out  4  memory address.
- mem_wdata  out  8  write data.
- mem_write  out  1  one-cycle write strobe.
- mem_read  out  1  one-cycle read strobe; mem_rdata valid the following cycle.
- mem_rdata  in  8  read data.
- pkt_data  out  8  byte to packetiser.
- pkt_valid  out  1  byte valid.
- pkt_ready  in  1  packetiser accepts.
- radio_busy  in  1  radio transmitting.
- radio_enable  out  1  radio on.
- count  out  5  stored bytes, 0..16.
- err  out  1  one-cycle pulse on a rejected instruction.

## Operation
- Opcodes:
  - 0 NOP: no effect.
  - 1 SAMPLE: take one sample and store it.
  - 2 SEND: drain the whole buffer to the packetiser.
  - 3 CLEAR: empty the buffer.
  - 4 RADIO_ON / 5 RADIO_OFF: set / clear radio_enable.
  - 6, 7: illegal; pulse err.
- inst_ready = enable & (state == IDLE). Accepted NOP, CLEAR, RADIO_* and illegal opcodes complete in the accept cycle; their effect is visible the next cycle and the FSM stays in IDLE.
- Buffer control: wr_ptr, rd_ptr (4 bits, wrap 15→0) and count (5 bits). CLEAR zeroes all three; memory contents are untouched.
- FSM states: IDLE, SENSE, WRITE, WAIT_RADIO, READ, LATCH, PRESENT.
- SAMPLE:
  - count == 16: err pulse, stay IDLE; the sample is dropped.
  - Otherwise IDLE→SENSE. SENSE holds sensor_enable for SETTLE_CYCLES cycles and captures sensor_data on the last of them.
  - SENSE→WRITE: mem_write=1, mem_addr=wr_ptr, mem_wdata=captured sample. wr_ptr+1 and count+1 at the end of the cycle.
  - WRITE→IDLE.
- SEND:
  - radio_enable == 0: err pulse, stay IDLE.
  - count == 0: no-op, stay IDLE, no err.
  - Otherwise →WAIT_RADIO, which holds while radio_busy = 1.
  - READ: mem_read=1, mem_addr=rd_ptr.
  - LATCH: mem_rdata is registered into pkt_data.
  - PRESENT: pkt_valid=1, pkt_data held stable until pkt_ready. On the handshake, rd_ptr+1 and count−1.
  - After the handshake: count (after decrement) > 0 →READ, else →IDLE.
  - radio_busy is checked only in WAIT_RADIO, not between bytes.
- enable low in any non-IDLE state:
  - Next edge forces IDLE and deasserts all strobes and pkt_valid.
  - An un-handshaken PRESENT byte is not consumed; pointers stay unchanged.
  - A sample in SENSE is discarded.
  - A WRITE already in progress completes its pointer update that cycle.
- mem_* outputs are 0 outside WRITE/READ.

## Timing
- Reset values: all outputs 0, including inst_ready, radio_enable, count, err, pkt_data, and mem_addr. State is IDLE.
- After reset release, inst_ready follows enable combinationally.
- SAMPLE accepted at cycle 0 (SETTLE_CYCLES=2):
  - sensor_enable high in cycles 1–2; capture at the end of cycle 2.
  - mem_write in cycle 3; count increments at the end of cycle 3.
  - inst_ready high again in cycle 4. busy is high in cycles 1–3.
- SEND with radio idle, accepted at cycle 0:
  - WAIT_RADIO is cycle 1; mem_read in cycle 2; LATCH in cycle 3; pkt_valid from cycle 4.
  - Each subsequent byte takes 3 cycles plus pkt_ready stall cycles.
  - Throughput is 1 byte per 3 cycles with pkt_ready tied high.
- err pulses exactly one cycle, in the cycle after the rejecting accept.
- count never exceeds 16 or underflows below 0. Full and empty both wrap pointers correctly (wr_ptr == rd_ptr with count 0 or 16).

## Structure
- Package node_pkg holds:
  - opcode localparams: OP_NOP, OP_SAMPLE, OP_SEND, OP_CLEAR, OP_RADIO_ON, OP_RADIO_OFF;
  - the FSM state encoding;
  - MEM_AW = 4 and the byte width.
- Sub-module node_ring_ctrl holds wr_ptr, rd_ptr and count with push, pop and clear inputs and full/empty outputs. The sequencer FSM instantiates it.

## Test plan
- Reset, then RADIO_ON, SAMPLE×3 with sensor_data 0x11, 0x22, 0x33, then SEND, pkt_ready=1 → pkt bytes 0x11, 0x22, 0x33 in order; count 3→0; busy low after the third handshake.
- 17 SAMPLEs → count=16 after the 16th; the 17th gives an err pulse and count stays 16. Then SEND → 16 bytes, the last being the 16th sample, with pointers wrapping through address 15→0.
- SEND with radio_enable=0 → err pulse, no mem_read. SEND with count=0 and radio on → no pkt_valid, no err.
- SEND with radio_busy=1 for 5 cycles → mem_read first asserted in the cycle after radio_busy falls. pkt_ready low 4 cycles in PRESENT → pkt_data stable, count unchanged until the handshake.
- enable dropped during PRESENT of byte 2 of 3 → IDLE next cycle, count stays 2. A fresh SEND then re-sends byte 2 first.
- Opcode 6, and CLEAR with count=5 → err pulse for 6; count=0 after CLEAR, and a following SEND issues no reads.

Source files
------------

// File: rtl/node_pkg.sv
// Shared constants for the sensor-node sequencer: opcodes, FSM encoding and
// buffer/datapath widths.
package node_pkg;
  localparam int MEM_AW = 4;
  localparam int DATA_W = 8;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SAMPLE    = 3'd1;
  localparam logic [2:0] OP_SEND      = 3'd2;
  localparam logic [2:0] OP_CLEAR     = 3'd3;
  localparam logic [2:0] OP_RADIO_ON  = 3'd4;
  localparam logic [2:0] OP_RADIO_OFF = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SENSE,
    ST_WRITE,
    ST_WAIT_RADIO,
    ST_READ,
    ST_LATCH,
    ST_PRESENT
  } state_e;
endpackage

// File: rtl/node_ring_ctrl.sv
// Circular-buffer bookkeeping: write/read pointers and occupancy count.
// Pointers wrap naturally; count disambiguates full from empty.
module node_ring_ctrl #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o   = (cnt_q == DEPTH_C);
  assign empty_o  = (cnt_q == '0);
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign wr_ptr_o = wr_q;
  assign rd_ptr_o = rd_q;
  assign count_o  = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/node_sequencer.sv
// Instruction-driven sequencer: samples the sensor into a circular buffer and
// drains it to the packetiser, owning the memory port and radio enable.
module node_sequencer
  import node_pkg::*;
#(
  parameter  int MEM_DEPTH     = 16,
  parameter  int SETTLE_CYCLES = 2,
  localparam int AW            = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [2:0]        inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic              busy,
  output logic              sensor_enable,
  input  logic [DATA_W-1:0] sensor_data,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  input  logic              radio_busy,
  output logic              radio_enable,
  output logic [AW:0]       count,
  output logic              err
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]   ONE = 1;

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [DATA_W-1:0] sample_q, sample_d, pkt_q, pkt_d;
  logic              radio_q, radio_d, err_q, err_d;
  logic              accept, push, pop, clear, full, empty;
  logic [AW-1:0]     wr_ptr, rd_ptr;

  // rst_n in the term keeps inst_ready low while reset is held.
  assign inst_ready   = enable & rst_n & (state_q == ST_IDLE);
  assign accept       = inst_valid & inst_ready;
  assign push         = (state_q == ST_WRITE);
  assign pkt_data     = pkt_q;
  assign radio_enable = radio_q;
  assign err          = err_q;

  node_ring_ctrl #(.AW(AW)) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .pop_i    (pop),
    .clear_i  (clear),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      sample_q <= '0;
      pkt_q    <= '0;
      radio_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sample_q <= sample_d;
      pkt_q    <= pkt_d;
      radio_q  <= radio_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sample_d = sample_q;
    pkt_d    = pkt_q;
    radio_d  = radio_q;
    err_d    = 1'b0;
    clear    = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        case (inst)
          OP_NOP: ;
          OP_SAMPLE: begin
            if (full) err_d = 1'b1;
            else begin
              state_d  = ST_SENSE;
              settle_d = '0;
            end
          end
          OP_SEND: begin
            if (!radio_q)    err_d   = 1'b1;
            else if (!empty) state_d = ST_WAIT_RADIO;
          end
          OP_CLEAR:     clear   = 1'b1;
          OP_RADIO_ON:  radio_d = 1'b1;
          OP_RADIO_OFF: radio_d = 1'b0;
          default:      err_d   = 1'b1;
        endcase
      end
      ST_SENSE: begin
        if (settle_q == SETTLE_LAST) begin
          sample_d = sensor_data;
          state_d  = ST_WRITE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_WRITE:      state_d = ST_IDLE;
      ST_WAIT_RADIO: if (!radio_busy) state_d = ST_READ;
      ST_READ:       state_d = ST_LATCH;
      ST_LATCH: begin
        pkt_d   = mem_rdata;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: if (pkt_ready) begin
        pop     = 1'b1;
        state_d = (count > ONE) ? ST_READ : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over every transition; a byte handshaken this cycle is still consumed.
    if (!enable && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    sensor_enable = (state_q == ST_SENSE);
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    pkt_valid     = 1'b0;
    case (state_q)
      ST_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = wr_ptr;
        mem_wdata = sample_q;
      end
      ST_READ: begin
        mem_read = 1'b1;
        mem_addr = rd_ptr;
      end
      ST_PRESENT: pkt_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_node_sequencer.sv
// Directed bench for node_sequencer: expected packet bytes go into a queue,
// a negedge monitor pops and compares them on each pkt handshake.
module tb_node_sequencer;
  import node_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [2:0] inst = 3'd0;
  logic       inst_valid = 1'b0, inst_ready, busy, sensor_enable;
  logic [7:0] sensor_data = 8'h00;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, pkt_data;
  logic       mem_write, mem_read, pkt_valid;
  logic       pkt_ready = 1'b1, radio_busy = 1'b0, radio_enable, err;
  logic [4:0] count;

  always #5 clk = ~clk;

  node_sequencer #(.MEM_DEPTH(16), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .busy(busy), .sensor_enable(sensor_enable),
    .sensor_data(sensor_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .radio_busy(radio_busy), .radio_enable(radio_enable), .count(count), .err(err)
  );

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  int checks = 0, errors = 0, rd_cnt = 0, pkt_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (mem_read) rd_cnt++;
    if (rst_n && pkt_valid && pkt_ready) begin
      checks++;
      pkt_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pkt_unexpected: got %02h, required no byte", pkt_data);
      end else begin
        e = exp_q.pop_front();
        if (pkt_data !== e) begin
          errors++;
          $display("FAIL pkt_byte: got %02h, required %02h", pkt_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns one cycle after the accept edge, at posedge+1.
  task automatic issue(input logic [2:0] op);
    int t = 0;
    while (!inst_ready && t < 200) begin step(); t++; end
    check("issue_ready_timeout", {31'd0, inst_ready}, 32'd1);
    inst = op; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin step(); t++; end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic sample(input logic [7:0] d);
    sensor_data = d;
    issue(OP_SAMPLE);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs, ps;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs",
          {inst_ready, busy, sensor_enable, mem_write, mem_read, pkt_valid, radio_enable, err},
          32'd0);
    check("rst_count", count, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1; enable = 1'b1;
    #1 check("ready_follows_enable", inst_ready, 1);
    step();

    // RADIO_ON then three samples, first one timed
    issue(OP_RADIO_ON);
    check("radio_on", radio_enable, 1);
    sensor_data = 8'h11;
    issue(OP_SAMPLE);
    check("s_c1_sensor_en", {sensor_enable, busy}, 2'b11);
    step();
    check("s_c2_sensor_en", sensor_enable, 1);
    step();
    check("s_c3_write", {mem_write, mem_addr, mem_wdata}, {1'b1, 4'd0, 8'h11});
    check("s_c3_sensor_off", sensor_enable, 0);
    step();
    check("s_c4_ready", {inst_ready, busy}, 2'b10);
    check("s_c4_count", count, 1);
    sample(8'h22);
    sample(8'h33);
    check("count3", count, 3);

    // SEND, timed; pkt_ready high
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    issue(OP_SEND);
    check("send_c1", {busy, mem_read}, 2'b10);
    step();
    check("send_c2_read", {mem_read, mem_addr}, {1'b1, 4'd0});
    step(); step();
    check("send_c4_pkt", {pkt_valid, pkt_data}, {1'b1, 8'h11});
    wait_idle();
    check("send_count0", count, 0);
    check("send_drained", exp_q.size(), 0);

    // fill to 16, 17th rejected, then drain with wrap
    for (int i = 0; i < 16; i++) sample(8'h40 + 8'(i));
    check("full_count", count, 16);
    sensor_data = 8'h99;
    issue(OP_SAMPLE);
    check("full_err", {err, busy}, 2'b10);
    step();
    check("full_err_one_cycle", err, 0);
    check("full_count_hold", count, 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
    issue(OP_SEND);
    wait_idle();
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_count0", count, 0);

    // SEND with radio off, then SEND with empty buffer
    issue(OP_RADIO_OFF);
    sample(8'h5A);
    rs = rd_cnt;
    issue(OP_SEND);
    check("radio_off_err", {err, busy}, 2'b10);
    repeat (3) step();
    check("radio_off_no_read", rd_cnt, rs);
    issue(OP_CLEAR);
    check("clear_count", count, 0);
    issue(OP_RADIO_ON);
    ps = pkt_cnt;
    issue(OP_SEND);
    check("empty_send_no_err", {err, busy}, 2'b00);
    repeat (4) step();
    check("empty_send_no_pkt", pkt_cnt, ps);
    check("empty_send_no_read", rd_cnt, rs);

    // radio_busy hold and pkt_ready stall
    sample(8'h66);
    radio_busy = 1'b1; pkt_ready = 1'b0;
    exp_q.push_back(8'h66);
    issue(OP_SEND);
    for (int i = 0; i < 5; i++) begin
      check("radio_busy_no_read", mem_read, 0);
      step();
    end
    radio_busy = 1'b0;
    check("busy_fall_no_read", mem_read, 0);
    step();
    check("read_after_fall", mem_read, 1);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      check("stall_pkt", {pkt_valid, pkt_data}, {1'b1, 8'h66});
      check("stall_count", count, 1);
      step();
    end
    pkt_ready = 1'b1;
    step();
    check("stall_done", {busy, count}, 6'd0);

    // enable drop during byte 2 of 3
    issue(OP_CLEAR);
    sample(8'hA1); sample(8'hA2); sample(8'hA3);
    exp_q.push_back(8'hA1);
    issue(OP_SEND);
    repeat (4) step();
    pkt_ready = 1'b0;
    step(); step();
    check("abort_pre_pkt", {pkt_valid, pkt_data}, {1'b1, 8'hA2});
    enable = 1'b0;
    step();
    check("abort_idle", {busy, pkt_valid, inst_ready}, 3'b000);
    check("abort_count", count, 2);
    enable = 1'b1; pkt_ready = 1'b1;
    exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    issue(OP_SEND);
    wait_idle();
    check("resend_drained", exp_q.size(), 0);
    check("resend_count", count, 0);

    // illegal opcode and CLEAR with 5 stored
    for (int i = 0; i < 5; i++) sample(8'hB0 + 8'(i));
    issue(3'd6);
    check("illegal_err", {err, busy}, 2'b10);
    check("illegal_count", count, 5);
    issue(OP_CLEAR);
    check("clear5_count", count, 0);
    check("clear5_no_err", err, 0);
    rs = rd_cnt;
    issue(OP_SEND);
    repeat (4) step();
    check("post_clear_no_read", rd_cnt, rs);
    check("post_clear_idle", busy, 0);

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
